// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared arbiter state encoding, requester indices and width helper
package mcu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_GRANT = 2'd2,
        ARB_TURN  = 2'd3
    } arb_state_t;

    localparam int REQ_DMA = 0;
    localparam int REQ_BLT = 1;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int width_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational lowest-index-first request encoder
module prio_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 68000 bus mastership sequencer for on-chip masters
module bus_arbiter
    import mcu_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int HOLD_MAX   = 64,
    parameter int TURNAROUND = 1,
    parameter int CHAIN      = 1
) (
    input  logic            clock,
    input  logic            resb,
    input  logic            as_n,
    input  logic            bg_n,
    output logic            br_n,
    output logic            bgack_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] yield,
    output logic            busy
);

    localparam int IW = width_min1(NREQ);
    localparam int HW = width_min1(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [1:0]    TURN_LOAD = 2'(TURNAROUND - 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [HW-1:0]   hold_inc;
    logic [1:0]      turn_q, turn_d;
    logic            br_n_q, br_n_d;
    logic            bgack_n_q, bgack_n_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] yield_q, yield_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            higher_pend;
    logic            other_pend;

    prio_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Pending-request summaries relative to the current winner.
    always_comb begin
        higher_pend = 1'b0;
        other_pend  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (IW'(i) < win_q))  higher_pend = 1'b1;
            if (req[i] && (IW'(i) != win_q)) other_pend  = 1'b1;
        end
    end

    // Next-state logic for the handshake FSM, hold counter and output registers.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        br_n_d    = br_n_q;
        bgack_n_d = bgack_n_q;
        gnt_d     = gnt_q;
        yield_d   = yield_q;
        hold_inc  = (hold_q == HOLD_LIM) ? hold_q : hold_q + HW'(1);

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    br_n_d  = 1'b0;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (!bg_n && as_n && req[win_q]) begin
                    bgack_n_d    = 1'b0;
                    gnt_d        = '0;
                    gnt_d[win_q] = 1'b1;
                    hold_d       = '0;
                    state_d      = ARB_GRANT;
                end else if (!req[win_q]) begin
                    if (pick_valid) begin
                        win_d = pick_idx;
                    end else begin
                        br_n_d  = 1'b1;
                        turn_d  = TURN_LOAD;
                        state_d = ARB_TURN;
                    end
                end
            end
            ARB_GRANT: begin
                // BR is dropped on the first grant clock so it overlaps BGACK by one clock.
                br_n_d = 1'b1;
                if (!req[win_q]) begin
                    gnt_d   = '0;
                    yield_d = '0;
                    hold_d  = '0;
                    turn_d  = TURN_LOAD;
                    state_d = ARB_TURN;
                end else begin
                    hold_d = hold_inc;
                    // Using the post-increment count makes yield land after exactly HOLD_MAX grant clocks.
                    if (higher_pend ||
                        ((HOLD_MAX != 0) && (hold_inc == HOLD_LIM) && other_pend)) begin
                        yield_d[win_q] = 1'b1;
                    end
                end
            end
            ARB_TURN: begin
                if (turn_q != 2'd0) begin
                    turn_d = turn_q - 2'd1;
                end else if ((CHAIN != 0) && pick_valid && !bgack_n_q) begin
                    win_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    hold_d          = '0;
                    state_d         = ARB_GRANT;
                end else begin
                    bgack_n_d = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clock or negedge resb) begin
        if (!resb) begin
            state_q   <= ARB_IDLE;
            win_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            gnt_q     <= '0;
            yield_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            br_n_q    <= br_n_d;
            bgack_n_q <= bgack_n_d;
            gnt_q     <= gnt_d;
            yield_q   <= yield_d;
            busy_q    <= busy_d;
        end
    end

    assign br_n    = br_n_q;
    assign bgack_n = bgack_n_q;
    assign gnt     = gnt_q;
    assign yield   = yield_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter (chained and unchained instances)
module tb_bus_arbiter;

    logic       clock;
    logic       resb;
    logic       as_n;
    logic       bg_n;
    logic [1:0] req;

    logic       a_br_n, a_bgack_n, a_busy;
    logic [1:0] a_gnt, a_yield;
    logic       b_br_n, b_bgack_n, b_busy;
    logic [1:0] b_gnt, b_yield;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int         sel;
        int         cyc;
        string      name;
        logic [6:0] exp_v;
    } exp_t;

    exp_t sb_q[$];
    event kick;

    bus_arbiter #(.NREQ(2), .HOLD_MAX(4), .TURNAROUND(1), .CHAIN(1)) u_dut_a (
        .clock(clock), .resb(resb), .as_n(as_n), .bg_n(bg_n),
        .br_n(a_br_n), .bgack_n(a_bgack_n), .req(req),
        .gnt(a_gnt), .yield(a_yield), .busy(a_busy)
    );

    bus_arbiter #(.NREQ(2), .HOLD_MAX(4), .TURNAROUND(1), .CHAIN(0)) u_dut_b (
        .clock(clock), .resb(resb), .as_n(as_n), .bg_n(bg_n),
        .br_n(b_br_n), .bgack_n(b_bgack_n), .req(req),
        .gnt(b_gnt), .yield(b_yield), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Monitor: pop every expectation due this cycle and compare against the selected instance.
    always begin : monitor
        exp_t e;
        logic [6:0] act;
        @(negedge clock or kick);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e   = sb_q.pop_front();
            act = (e.sel == 0) ? {a_br_n, a_bgack_n, a_gnt, a_yield, a_busy}
                               : {b_br_n, b_bgack_n, b_gnt, b_yield, b_busy};
            checks++;
            if (e.cyc != cyc_cnt) begin
                failures++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc_cnt);
            end else if (act !== e.exp_v) begin
                failures++;
                $display("FAIL %s actual={br_n,bgack_n,gnt,yield,busy}=%b required=%b",
                         e.name, act, e.exp_v);
            end
        end
    end

    task automatic push(input int sel, input int dc, input string name, input logic br,
                        input logic bga, input logic [1:0] g, input logic [1:0] y, input logic b);
        exp_t e;
        e.sel   = sel;
        e.cyc   = cyc_cnt + dc;
        e.name  = name;
        e.exp_v = {br, bga, g, y, b};
        sb_q.push_back(e);
    endtask

    // Expectation for the outputs right after the next clock edge.
    task automatic ex(input int sel, input string name, input logic br, input logic bga,
                      input logic [1:0] g, input logic [1:0] y, input logic b);
        push(sel, 1, name, br, bga, g, y, b);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic bg, input logic as_v);
        req  = r;
        bg_n = bg;
        as_n = as_v;
    endtask

    initial begin
        resb = 1'b1;
        drive(2'b11, 1'b1, 1'b1);
        #1;
        resb = 1'b0;

        // 1. reset holds everything inactive even with both requests up
        for (int i = 0; i < 3; i++) begin
            ex(0, "reset_idle", 1, 1, 2'b00, 2'b00, 0);
            tick();
        end
        drive(2'b00, 1'b1, 1'b1);
        resb = 1'b1;
        ex(0, "post_reset_idle", 1, 1, 2'b00, 2'b00, 0);
        tick();

        // 2. single DMA request through the full handshake
        drive(2'b01, 1'b1, 1'b1);
        ex(0, "single_br", 0, 1, 2'b00, 2'b00, 1); tick();
        ex(0, "single_wait1", 0, 1, 2'b00, 2'b00, 1); tick();
        ex(0, "single_wait2", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b01, 1'b0, 1'b1);
        ex(0, "single_grant", 0, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b01, 1'b1, 1'b1);
        ex(0, "single_br_drop", 1, 0, 2'b01, 2'b00, 1); tick();
        ex(0, "single_hold", 1, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b00, 1'b1, 1'b1);
        ex(0, "single_release", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(0, "single_bgack_up", 1, 1, 2'b00, 2'b00, 0); tick();

        // 3. blitter holds, DMA preempts via yield, chained handover
        drive(2'b10, 1'b1, 1'b1);
        ex(0, "prio_br", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b10, 1'b0, 1'b1);
        ex(0, "prio_grant_blt", 0, 0, 2'b10, 2'b00, 1); tick();
        drive(2'b10, 1'b1, 1'b1);
        ex(0, "prio_blt_hold", 1, 0, 2'b10, 2'b00, 1); tick();
        drive(2'b11, 1'b1, 1'b1);
        ex(0, "prio_yield", 1, 0, 2'b10, 2'b10, 1); tick();
        ex(0, "prio_yield_sticky", 1, 0, 2'b10, 2'b10, 1); tick();
        drive(2'b01, 1'b1, 1'b1);
        ex(0, "prio_release", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(0, "prio_chain_dma", 1, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b00, 1'b1, 1'b1);
        ex(0, "prio_dma_release", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(0, "prio_idle", 1, 1, 2'b00, 2'b00, 0); tick();

        // 4. hold limit: DMA holds with blitter pending, then blitter holds alone
        drive(2'b01, 1'b1, 1'b1);
        ex(0, "hold_br", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b11, 1'b0, 1'b1);
        ex(0, "hold_grant", 0, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b11, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            ex(0, $sformatf("hold_clk%0d_no_yield", i), 1, 0, 2'b01, 2'b00, 1);
            tick();
        end
        ex(0, "hold_limit_yield", 1, 0, 2'b01, 2'b01, 1); tick();
        ex(0, "hold_yield_sticky", 1, 0, 2'b01, 2'b01, 1); tick();
        drive(2'b10, 1'b1, 1'b1);
        ex(0, "hold_release", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(0, "hold_chain_blt", 1, 0, 2'b10, 2'b00, 1); tick();
        for (int i = 0; i < 6; i++) begin
            ex(0, $sformatf("hold_alone%0d_no_yield", i), 1, 0, 2'b10, 2'b00, 1);
            tick();
        end
        drive(2'b00, 1'b1, 1'b1);
        ex(0, "hold_blt_release", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(0, "hold_idle", 1, 1, 2'b00, 2'b00, 0); tick();

        // 5. cancel before grant; bg_n low with as_n low must not grant
        drive(2'b01, 1'b1, 1'b1);
        ex(0, "cancel_br", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b01, 1'b0, 1'b0);
        ex(0, "cancel_as_low_no_grant", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b00, 1'b1, 1'b1);
        ex(0, "cancel_br_up", 1, 1, 2'b00, 2'b00, 1); tick();
        ex(0, "cancel_idle", 1, 1, 2'b00, 2'b00, 0); tick();

        // 7. async reset in the middle of a grant
        drive(2'b10, 1'b1, 1'b1);
        ex(0, "areset_br", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b10, 1'b0, 1'b1);
        ex(0, "areset_grant", 0, 0, 2'b10, 2'b00, 1); tick();
        drive(2'b10, 1'b1, 1'b1);
        ex(0, "areset_holding", 1, 0, 2'b10, 2'b00, 1); tick();
        @(negedge clock);
        #1;
        resb = 1'b0;
        #1;
        push(0, 0, "areset_no_edge", 1, 1, 2'b00, 2'b00, 0);
        -> kick;
        #1;
        drive(2'b00, 1'b1, 1'b1);
        ex(0, "areset_held", 1, 1, 2'b00, 2'b00, 0); tick();
        resb = 1'b1;
        ex(1, "nochain_start_idle", 1, 1, 2'b00, 2'b00, 0); tick();

        // 6. CHAIN=0: back-to-back blitter then DMA goes through the CPU
        drive(2'b10, 1'b1, 1'b1);
        ex(1, "nochain_br1", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b10, 1'b0, 1'b1);
        ex(1, "nochain_grant1", 0, 0, 2'b10, 2'b00, 1); tick();
        drive(2'b10, 1'b1, 1'b1);
        ex(1, "nochain_hold1", 1, 0, 2'b10, 2'b00, 1); tick();
        drive(2'b01, 1'b1, 1'b1);
        ex(1, "nochain_release1", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(1, "nochain_bgack_up", 1, 1, 2'b00, 2'b00, 0);
        ex(0, "chain_contrast", 1, 0, 2'b01, 2'b00, 1); tick();
        ex(1, "nochain_br2", 0, 1, 2'b00, 2'b00, 1); tick();
        drive(2'b01, 1'b0, 1'b1);
        ex(1, "nochain_grant2", 0, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b01, 1'b1, 1'b1);
        ex(1, "nochain_hold2", 1, 0, 2'b01, 2'b00, 1); tick();
        drive(2'b00, 1'b1, 1'b1);
        ex(1, "nochain_release2", 1, 0, 2'b00, 2'b00, 1); tick();
        ex(1, "nochain_idle", 1, 1, 2'b00, 2'b00, 0); tick();

        tick();
        tick();
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
            failures += sb_q.size();
            checks   += sb_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
